// File: rtl/bench_seq_pkg.sv
// Shared types and LFSR/MISR step functions for the benchmark vector sequencer.
// Used by bench_vector_sequencer and bench_misr.
package bench_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    APPLY,
    CAPTURE,
    DONE
  } state_t;

  localparam int          LFSR_W     = 8;
  localparam logic [7:0]  LFSR_SEED0 = 8'h01;
  localparam logic [31:0] MISR_POLY  = 32'h0000_1021;

  // x^8+x^6+x^5+x^4+1, Fibonacci form
  function automatic logic [7:0] lfsr_next(
    input logic [7:0] l
  );
    return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
  endfunction

  // w-bit MISR step, computed in a 32-bit container and masked to w
  function automatic logic [31:0] misr_next(
    input logic [31:0] s,
    input logic [31:0] d,
    input int          w
  );
    logic [31:0] m;
    logic [31:0] n;
    m = (w >= 32) ? '1 : ((32'h1 << w) - 32'h1);
    n = {s[30:0], 1'b0}
      ^ (s[5'(w - 1)] ? MISR_POLY : 32'h0)
      ^ d;
    return n & m;
  endfunction

endpackage

// File: rtl/bench_misr.sv
// Multiple-input signature register compacting DUT responses.
// Clear has priority over shift-enable.
module bench_misr
  import bench_seq_pkg::*;
#(
  parameter int SIG_W = 16,
  parameter int DIN_W = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic [DIN_W-1:0] din,
  output logic [SIG_W-1:0] sig
);

  logic [SIG_W-1:0] sig_nxt;

  assign sig_nxt = SIG_W'(misr_next(32'(sig), 32'(din), SIG_W));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig <= '0;
    end else if (clr) begin
      sig <= '0;
    end else if (en) begin
      sig <= sig_nxt;
    end
  end

endmodule

// File: rtl/bench_vector_sequencer.sv
// Self-test sequencer: init DUT flops, apply LFSR vectors, compact into a MISR.
// Optional golden compare (pass/fail ports) with `define BENCH_SEQ_GOLDEN_CHECK_EN.
module bench_vector_sequencer
  import bench_seq_pkg::*;
#(
  parameter  int NUM_IN      = 4,
  parameter  int NUM_OUT     = 1,
  parameter  int NUM_PAT     = 16,
  parameter  int INIT_CYCLES = 3,
  parameter  int SIG_W       = 16,
  localparam int PW          = $clog2(NUM_PAT + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  input  logic [7:0]         seed,
  output logic [NUM_IN-1:0]  dut_in,
  output logic               dut_en,
  output logic               dut_init,
  input  logic [NUM_OUT-1:0] dut_out,
  output logic               busy,
  output logic               done,
  output logic [PW-1:0]      pat_idx,
  output logic [SIG_W-1:0]   signature
`ifdef BENCH_SEQ_GOLDEN_CHECK_EN
  ,
  input  logic [SIG_W-1:0]   golden_sig,
  output logic               pass,
  output logic               fail
`endif
);

  localparam int IW = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;

  state_t            state_q;
  state_t            state_d;
  logic [IW-1:0]     icnt_q;
  logic [LFSR_W-1:0] lfsr_q;
  logic              accept;
  logic              capture;
  logic              last_init;
  logic              last_pat;

  assign accept    = (state_q == IDLE) & start & ~abort;
  assign capture   = (state_q == CAPTURE) & ~abort;
  assign last_init = (icnt_q == IW'(INIT_CYCLES - 1));
  assign last_pat  = (pat_idx == PW'(NUM_PAT - 1));

  always_comb begin
    state_d  = state_q;
    dut_in   = '0;
    dut_en   = 1'b0;
    dut_init = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) state_d = INIT;
      end
      INIT: begin
        busy     = 1'b1;
        dut_en   = 1'b1;
        dut_init = 1'b1;
        if (last_init) state_d = APPLY;
      end
      APPLY: begin
        busy    = 1'b1;
        dut_in  = lfsr_q[NUM_IN-1:0];
        state_d = CAPTURE;
      end
      CAPTURE: begin
        busy    = 1'b1;
        dut_in  = lfsr_q[NUM_IN-1:0];
        dut_en  = 1'b1;
        state_d = last_pat ? DONE : APPLY;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (abort) state_d = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      icnt_q  <= '0;
      lfsr_q  <= LFSR_SEED0;
      pat_idx <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        lfsr_q  <= (seed == 8'h00) ? LFSR_SEED0 : seed;
        pat_idx <= '0;
        icnt_q  <= '0;
      end else begin
        if (state_q == INIT) icnt_q <= icnt_q + IW'(1);
        if (capture) begin
          lfsr_q  <= lfsr_next(lfsr_q);
          pat_idx <= pat_idx + PW'(1);
        end
      end
    end
  end

  bench_misr #(
    .SIG_W (SIG_W),
    .DIN_W (NUM_OUT)
  ) u_misr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (accept),
    .en    (capture),
    .din   (dut_out),
    .sig   (signature)
  );

`ifdef BENCH_SEQ_GOLDEN_CHECK_EN
  logic pass_q;
  logic fail_q;
  logic match;

  assign match = (signature == golden_sig);

  // verdict is live during DONE, then frozen until the next start/abort
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pass_q <= 1'b0;
      fail_q <= 1'b0;
    end else if (accept | abort) begin
      pass_q <= 1'b0;
      fail_q <= 1'b0;
    end else if (state_q == DONE) begin
      pass_q <= match;
      fail_q <= ~match;
    end
  end

  assign pass = (state_q == DONE) ? match  : pass_q;
  assign fail = (state_q == DONE) ? ~match : fail_q;
`endif

endmodule
